// File: rtl/dff_pipe_sync_reset.sv
// WIDTH-bit, DEPTH-stage retiming pipeline with valid/ready flow control,
// bubble collapsing, synchronous flush and a registered occupancy count.
module dff_pipe_sync_reset #(
  parameter int               WIDTH       = 8,
  parameter int               DEPTH       = 3,
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] stage_data [DEPTH];
  logic [DEPTH-1:0] stage_vld;
  logic [DEPTH-1:0] can;
  logic             in_fire;
  logic             out_fire;

  // A stage may load when it is empty or its downstream neighbour can load;
  // a running carry avoids a self-referencing vector in the chain.
  always_comb begin
    logic c;
    can = '0;
    c   = !stage_vld[DEPTH-1] || out_ready;
    can[DEPTH-1] = c;
    for (int i = DEPTH - 2; i >= 0; i--) begin
      c      = !stage_vld[i] || c;
      can[i] = c;
    end
  end

  assign in_ready  = can[0] && !flush && !reset;
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  assign out_data  = stage_data[DEPTH-1];
  assign out_valid = stage_vld[DEPTH-1];

  // Stage registers: bubbles advance the valid bit but never overwrite data.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      stage_vld <= '0;
      for (int i = 0; i < DEPTH; i++) stage_data[i] <= RESET_VALUE;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (can[i]) begin
          if (i == 0) begin
            stage_vld[i] <= in_fire;
            if (in_fire) stage_data[i] <= in_data;
          end else begin
            stage_vld[i] <= stage_vld[i-1];
            if (stage_vld[i-1]) stage_data[i] <= stage_data[i-1];
          end
        end
      end
    end
  end

  // Occupancy: out_fire during flush/reset is discarded along with the item.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      count <= '0;
    end else begin
      count <= count + CW'(in_fire) - CW'(out_fire);
    end
  end

endmodule

// File: tb/tb_dff_pipe_sync_reset.sv
// Directed vector table plus hand sequences and a queue-scoreboard soak
// for dff_pipe_sync_reset (WIDTH=8, DEPTH=3).
module tb_dff_pipe_sync_reset;

  logic       clk = 1'b0;
  logic       reset, flush, in_valid, out_ready;
  logic [7:0] in_data;
  logic       in_ready, out_valid;
  logic [7:0] out_data;
  logic [1:0] count;
  logic       c3_in_ready, c3_out_valid;
  logic [7:0] c3_out_data;
  logic [1:0] c3_count;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  dff_pipe_sync_reset #(.WIDTH(8), .DEPTH(3)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .count(count)
  );

  dff_pipe_sync_reset #(.WIDTH(8), .DEPTH(3), .RESET_VALUE(8'hC3)) dut_c3 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_data(in_data), .in_valid(in_valid), .in_ready(c3_in_ready),
    .out_data(c3_out_data), .out_valid(c3_out_valid), .out_ready(out_ready),
    .count(c3_count)
  );

  typedef struct {
    logic       rst, fl, iv;
    logic [7:0] id;
    logic       ordy;
    logic       e_ir, e_ov;
    logic [7:0] e_od;
    logic [1:0] e_cnt;
  } vec_t;

  vec_t vecs [31];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic f, input logic iv, input logic [7:0] d,
                       input logic o);
    reset = r; flush = f; in_valid = iv; in_data = d; out_ready = o;
  endtask

  logic [7:0] q [$];
  logic       prev_stall;
  logic [7:0] prev_data;
  logic       exp_ir;

  initial begin
    // rst fl iv id orы: inputs; then expected in_ready, out_valid, out_data, count
    vecs[0]  = '{0,0,1,8'h01,1, 1,0,8'h00,2'd0};
    vecs[1]  = '{0,0,1,8'h02,1, 1,0,8'h00,2'd1};
    vecs[2]  = '{0,0,1,8'h03,1, 1,0,8'h00,2'd2};
    vecs[3]  = '{0,0,0,8'h00,1, 1,1,8'h01,2'd3};
    vecs[4]  = '{0,0,0,8'h00,1, 1,1,8'h02,2'd2};
    vecs[5]  = '{0,0,0,8'h00,1, 1,1,8'h03,2'd1};
    vecs[6]  = '{0,0,1,8'hA1,0, 1,0,8'h03,2'd0};
    vecs[7]  = '{0,0,1,8'hA2,0, 1,0,8'h03,2'd1};
    vecs[8]  = '{0,0,1,8'hA3,0, 1,0,8'h03,2'd2};
    vecs[9]  = '{0,0,1,8'hA4,0, 0,1,8'hA1,2'd3};
    vecs[10] = '{0,0,1,8'hA4,0, 0,1,8'hA1,2'd3};
    vecs[11] = '{0,0,1,8'hA4,1, 1,1,8'hA1,2'd3};
    vecs[12] = '{0,0,0,8'h00,1, 1,1,8'hA2,2'd3};
    vecs[13] = '{0,0,0,8'h00,1, 1,1,8'hA3,2'd2};
    vecs[14] = '{0,0,0,8'h00,1, 1,1,8'hA4,2'd1};
    vecs[15] = '{0,0,1,8'h10,0, 1,0,8'hA4,2'd0};
    vecs[16] = '{0,0,0,8'h00,0, 1,0,8'hA4,2'd1};
    vecs[17] = '{0,0,0,8'h00,0, 1,0,8'hA4,2'd1};
    vecs[18] = '{0,0,1,8'h20,0, 1,1,8'h10,2'd1};
    vecs[19] = '{0,0,0,8'h00,0, 1,1,8'h10,2'd2};
    vecs[20] = '{0,0,0,8'h00,0, 1,1,8'h10,2'd2};
    vecs[21] = '{0,0,1,8'h30,0, 1,1,8'h10,2'd2};
    vecs[22] = '{0,1,1,8'h55,1, 0,1,8'h10,2'd3};
    vecs[23] = '{0,0,0,8'h00,1, 1,0,8'h00,2'd0};
    vecs[24] = '{0,0,0,8'h00,1, 1,0,8'h00,2'd0};
    vecs[25] = '{0,0,0,8'h00,1, 1,0,8'h00,2'd0};
    vecs[26] = '{0,0,1,8'hB1,0, 1,0,8'h00,2'd0};
    vecs[27] = '{0,0,1,8'hB2,0, 1,0,8'h00,2'd1};
    vecs[28] = '{0,0,1,8'hB3,0, 1,0,8'h00,2'd2};
    vecs[29] = '{1,1,1,8'hB4,1, 0,1,8'hB1,2'd3};
    vecs[30] = '{0,0,0,8'h00,1, 1,0,8'h00,2'd0};

    drive(1, 0, 0, 8'h00, 1);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'h00);
    chk("rst_out_data_c3", 32'(c3_out_data), 32'hC3);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    reset = 1'b0;
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    for (int i = 0; i < 31; i++) begin
      drive(vecs[i].rst, vecs[i].fl, vecs[i].iv, vecs[i].id, vecs[i].ordy);
      #1;
      chk($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].e_ir));
      chk($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].e_ov));
      chk($sformatf("v%0d_out_data", i), 32'(out_data), 32'(vecs[i].e_od));
      chk($sformatf("v%0d_count", i), 32'(count), 32'(vecs[i].e_cnt));
      @(posedge clk);
      #1;
    end

    // Flush with a programmable reset value: data stages must reload 0xC3.
    drive(0, 0, 1, 8'hE1, 0);
    @(posedge clk); #1;
    chk("c3_count_one", 32'(c3_count), 32'd1);
    drive(0, 1, 0, 8'h00, 0);
    @(posedge clk); #1;
    drive(0, 0, 0, 8'h00, 0);
    #1;
    chk("c3_flush_out_data", 32'(c3_out_data), 32'hC3);
    chk("c3_flush_out_valid", 32'(c3_out_valid), 32'd0);
    chk("c3_flush_count", 32'(c3_count), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("c3_idle_out_data", 32'(c3_out_data), 32'hC3);

    // Soak against a FIFO-order scoreboard; the DUT is empty here.
    prev_stall = 1'b0;
    prev_data  = 8'h00;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      drive(0, ($urandom_range(0, 63) == 0), 1'($urandom_range(0, 1)),
            8'($urandom_range(0, 255)), ($urandom_range(0, 3) != 0));
      #1;
      exp_ir = !flush && !(q.size() == 3 && !out_ready);
      chk("soak_count", 32'(count), 32'(q.size()));
      chk("soak_in_ready", 32'(in_ready), 32'(exp_ir));
      if (prev_stall) begin
        chk("soak_stall_valid", 32'(out_valid), 32'd1);
        chk("soak_stall_data", 32'(out_data), 32'(prev_data));
      end
      if (out_valid) begin
        chk("soak_nonempty", 32'(q.size() > 0), 32'd1);
        if (q.size() > 0) chk("soak_order", 32'(out_data), 32'(q[0]));
      end
      prev_stall = out_valid && !out_ready && !flush;
      prev_data  = out_data;
      if (flush) begin
        q.delete();
      end else begin
        if (out_valid && out_ready && q.size() > 0) void'(q.pop_front());
        if (in_valid && exp_ir) q.push_back(in_data);
      end
      @(posedge clk);
      #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
